// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//   Two-stage RISC-V instruction encoder (inverse of the immediate generator).
//   Takes decoded fields plus a full 32-bit immediate, checks that the
//   immediate fits the format, and scatters it into the instruction word.
//   Bundles whose immediate does not fit (or whose itype is unknown) are still
//   delivered in order, with inst=0 and err=1.
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid / in_ready   : input handshake for the field bundle
//   itype, opcode, funct3, funct7, rd, rs1, rs2, imm : decoded fields
//   out_valid / out_ready : output handshake
//   inst, err             : encoded word and illegal flag (qualified by out_valid)
//   enc_count             : words delivered with err=0 (wraps)
//   err_count             : words delivered with err=1 (saturates)
// -----------------------------------------------------------------------------
module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       itype,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    // Format codes shared with the decoder; NULL_TYPE is R-format.
    localparam logic [2:0] NULL_TYPE = 3'd0;
    localparam logic [2:0] I_TYPE    = 3'd1;
    localparam logic [2:0] S_TYPE    = 3'd2;
    localparam logic [2:0] U_TYPE    = 3'd3;
    localparam logic [2:0] J_TYPE    = 3'd4;

    localparam logic [6:0] OP_IMM = 7'b0010011;

    // ---------------- handshake ----------------
    logic r_s1_valid, r_s2_valid;
    logic w_s2_free, w_in_fire, w_s1_adv, w_out_fire;

    assign w_s2_free  = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_free;
    assign w_in_fire  = in_valid && in_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    assign w_out_fire = r_s2_valid && out_ready;

    // ---------------- legality (on the incoming bundle) ----------------
    logic w_shift, w_legal;
    logic w_sext12, w_sext21;

    // slli/srli/srai carry funct7 in the upper immediate bits.
    assign w_shift  = (itype == I_TYPE) && (opcode == OP_IMM) &&
                      (funct3 == 3'b001 || funct3 == 3'b101);
    // imm[31:11] all equal: value fits a signed 12-bit field.
    assign w_sext12 = (&imm[31:11]) || !(|imm[31:11]);
    // imm[31:20] all equal: value fits the signed 21-bit J range.
    assign w_sext21 = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        w_legal = 1'b0;
        case (itype)
            I_TYPE:    w_legal = w_shift ? (imm[31:5] == 27'd0) : w_sext12;
            S_TYPE:    w_legal = w_sext12;
            U_TYPE:    w_legal = (imm[11:0] == 12'd0);
            J_TYPE:    w_legal = !imm[0] && w_sext21;
            NULL_TYPE: w_legal = 1'b1;
            default:   w_legal = 1'b0;
        endcase
    end

    // ---------------- stage 1: captured fields ----------------
    logic [2:0]  r_s1_type;
    logic [6:0]  r_s1_op, r_s1_f7;
    logic [2:0]  r_s1_f3;
    logic [4:0]  r_s1_rd, r_s1_rs1, r_s1_rs2;
    logic [31:0] r_s1_imm;
    logic        r_s1_shift, r_s1_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_type  <= '0;
            r_s1_op    <= '0;
            r_s1_f7    <= '0;
            r_s1_f3    <= '0;
            r_s1_rd    <= '0;
            r_s1_rs1   <= '0;
            r_s1_rs2   <= '0;
            r_s1_imm   <= '0;
            r_s1_shift <= 1'b0;
            r_s1_legal <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_type  <= itype;
                r_s1_op    <= opcode;
                r_s1_f7    <= funct7;
                r_s1_f3    <= funct3;
                r_s1_rd    <= rd;
                r_s1_rs1   <= rs1;
                r_s1_rs2   <= rs2;
                r_s1_imm   <= imm;
                r_s1_shift <= w_shift;
                r_s1_legal <= w_legal;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // ---------------- packing (from stage 1) ----------------
    logic [31:0] w_inst;

    always_comb begin
        w_inst = '0;
        if (r_s1_legal) begin
            case (r_s1_type)
                I_TYPE: w_inst = r_s1_shift ?
                    {r_s1_f7, r_s1_imm[4:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op} :
                    {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
                S_TYPE: w_inst = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                                  r_s1_imm[4:0], r_s1_op};
                U_TYPE: w_inst = {r_s1_imm[31:12], r_s1_rd, r_s1_op};
                J_TYPE: w_inst = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                                  r_s1_imm[19:12], r_s1_rd, r_s1_op};
                default: w_inst = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3,
                                   r_s1_rd, r_s1_op};
            endcase
        end
    end

    // ---------------- stage 2: output register + counters ----------------
    logic [31:0]      r_s2_inst;
    logic             r_s2_err;
    logic [CNT_W-1:0] r_enc_cnt, r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_inst  <= '0;
            r_s2_err   <= 1'b0;
            r_enc_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            // A new word may replace one being drained in the same cycle.
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_inst  <= w_inst;
                r_s2_err   <= !r_s1_legal;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end

            if (w_out_fire) begin
                if (r_s2_err) begin
                    if (r_err_cnt != '1)
                        r_err_cnt <= r_err_cnt + 1'b1;
                end else begin
                    r_enc_cnt <= r_enc_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign inst      = r_s2_inst;
    assign err       = r_s2_err;
    assign enc_count = r_enc_cnt;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

    localparam logic [2:0] NULL_T = 3'd0;
    localparam logic [2:0] I_T    = 3'd1;
    localparam logic [2:0] S_T    = 3'd2;
    localparam logic [2:0] U_T    = 3'd3;
    localparam logic [2:0] J_T    = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [2:0]  itype;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        in_ready, out_valid, err;
    logic [31:0] inst;
    logic [15:0] enc_count, err_count;

    logic        in_ready4, out_valid4, err4;
    logic [31:0] inst4;
    logic [3:0]  enc_count4, err_count4;

    always #5 clk = ~clk;

    inst_encoder #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .itype(itype), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .inst(inst), .err(err),
        .enc_count(enc_count), .err_count(err_count)
    );

    // Narrow-counter copy fed with the same stimulus.
    inst_encoder #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .itype(itype), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid4), .out_ready(out_ready), .inst(inst4), .err(err4),
        .enc_count(enc_count4), .err_count(err_count4)
    );

    typedef struct {
        logic [31:0] exp_inst;
        logic        exp_err;
        logic        rt;
        logic [2:0]  t;
        logic [31:0] imm;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Decoder view of the immediate, used for round-trip checks.
    function automatic logic [31:0] dec_imm(input logic [2:0] t, input logic [31:0] w);
        case (t)
            I_T:     return {{20{w[31]}}, w[31:20]};
            S_T:     return {{20{w[31]}}, w[31:25], w[11:7]};
            U_T:     return {w[31:12], 12'd0};
            J_T:     return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        stall_prev = 1'b0;
    logic [31:0] prev_inst;
    logic        prev_err;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                if (stall_prev) begin
                    chk("stall_inst_hold", inst, prev_inst);
                    chk("stall_err_hold", {31'd0, err}, {31'd0, prev_err});
                end
                stall_prev = 1'b1;
                prev_inst  = inst;
                prev_err   = err;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", inst, 32'hxxxx_xxxx);
                end else begin
                    e = q.pop_front();
                    chk("inst", inst, e.exp_inst);
                    chk("err", {31'd0, err}, {31'd0, e.exp_err});
                    if (e.rt) chk("roundtrip_imm", dec_imm(e.t, inst), e.imm);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im,
                        input logic [31:0] ei, input logic ee, input logic rt);
        exp_t e;
        int   n = 0;
        itype = t; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            e.exp_inst = ei; e.exp_err = ee; e.rt = rt; e.t = t; e.imm = im;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((q.size() != 0 || out_valid) && n < 200);
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_addi();
        send(I_T, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] enc_before;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        itype = '0; opcode = '0; funct3 = '0; funct7 = '0;
        rd = '0; rs1 = '0; rs2 = '0; imm = '0;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Backpressure: 4 back-to-back bundles, out_ready low for 5 cycles
        out_ready = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("no_gap_out_valid", {31'd0, out_valid}, 32'd1);
                end
            end
        join_none
        send(NULL_T, 7'b0110011, 3'd0, 7'd0,  5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, 1'b0);
        send(NULL_T, 7'b0110011, 3'd0, 7'h20, 5'd4, 5'd1, 5'd2, 32'd0, 32'h40208233, 1'b0, 1'b0);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_first_word", inst, 32'h002081B3);
        send(NULL_T, 7'b0110011, 3'd7, 7'd0,  5'd5, 5'd3, 5'd4, 32'd0, 32'h0041F2B3, 1'b0, 1'b0);
        send(NULL_T, 7'b0110011, 3'd6, 7'd0,  5'd6, 5'd3, 5'd4, 32'd0, 32'h0041E333, 1'b0, 1'b0);
        drain();
        chk("bp_enc_count", {16'd0, enc_count}, 32'd4);

        // I and shift with latency check
        send_addi();
        @(negedge clk);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        send(I_T, 7'b0010011, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030D093, 1'b0, 1'b0);

        // S / U / J with round trip
        send(S_T, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0, 1'b1);
        send(U_T, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0, 1'b1);
        send(J_T, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF, 1'b0, 1'b1);
        send(I_T, 7'b0000011, 3'd2, 7'd0, 5'd7, 5'd2, 5'd0, 32'hFFFFF800, 32'h80012383, 1'b0, 1'b1);
        drain();

        // Illegal immediates
        enc_before = enc_count;
        send(I_T, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'd0, 1'b1, 1'b0);
        drain();
        chk("ill_err_count_1", {16'd0, err_count}, 32'd1);
        send(J_T, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000003, 32'd0, 1'b1, 1'b0);
        send(U_T, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00000001, 32'd0, 1'b1, 1'b0);
        send(3'd7, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0,      32'd0, 1'b1, 1'b0);
        drain();
        chk("ill_err_count_4", {16'd0, err_count}, 32'd4);
        chk("ill_enc_unchanged", {16'd0, enc_count}, {16'd0, enc_before});

        // Reset mid-flight with both stages full
        out_ready = 1'b0;
        send(U_T, 7'b0110111, 3'd0, 7'd0, 5'd9,  5'd0, 5'd0, 32'hABCDE000, 32'hABCDE4B7, 1'b0, 1'b0);
        send(U_T, 7'b0110111, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h11111000, 32'h11111537, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_enc_count", {16'd0, enc_count}, 32'd0);
        chk("mid_rst_err_count", {16'd0, err_count}, 32'd0);
        chk("mid_rst_inst", inst, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_addi();
        @(negedge clk);
        chk("post_rst_lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("post_rst_lat_valid", {31'd0, out_valid}, 32'd1);
        drain();
        chk("post_rst_enc_count", {16'd0, enc_count}, 32'd1);

        // Counter limits: 17 illegal + 17 legal
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 17; k++)
            send(U_T, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00000001, 32'd0, 1'b1, 1'b0);
        for (int k = 0; k < 17; k++)
            send_addi();
        drain();
        chk("cnt4_err_sat", {28'd0, err_count4}, 32'd15);
        chk("cnt4_enc_wrap", {28'd0, enc_count4}, 32'd1);
        chk("cnt16_err", {16'd0, err_count}, 32'd17);
        chk("cnt16_enc", {16'd0, enc_count}, 32'd17);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

- Pipelined RISC-V instruction encoder: the inverse of the immediate generator.
- Accepts decoded fields (format type, opcode, funct3/funct7, register indices, full 32-bit immediate) and scatters the immediate into the format's bit layout to produce a 32-bit instruction word.
- Checks that each immediate is representable in its format, and counts encoded and rejected words.
- Sits in the npc test/trace path and feeds self-generated instruction streams into memory images and round-trip checks against the decoder.

## Interface
Parameters:
- CNT_W, default 16, width of the `enc_count` and `err_count` counters.

Ports:
- `clk`, input, 1, sole clock, rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `in_valid`, input, 1, field bundle valid.
- `in_ready`, output, 1, encoder can accept.
- `itype`, input, 3, shared `I_TYPE`/`U_TYPE`/`J_TYPE`/`S_TYPE`/`NULL_TYPE` constants; `NULL_TYPE` means R-format.
- `opcode`, input, 7.
- `funct3`, input, 3.
- `funct7`, input, 7.
- `rd`, input, 5.
- `rs1`, input, 5.
- `rs2`, input, 5.
- `imm`, input, 32, immediate as the decoder would output it.
- `out_valid`, output, 1.
- `out_ready`, input, 1.
- `inst`, output, 32, encoded word.
- `err`, output, 1, immediate not representable or unknown itype; qualified by `out_valid`.
- `enc_count`, output, CNT_W, words delivered with `err`=0; wraps.
- `err_count`, output, CNT_W, words delivered with `err`=1; saturates at all-ones.

## Operation
Packing (square brackets are `imm` bits):
- I: {[11:0], rs1, funct3, rd, opcode}. Legal iff [31:11] are all equal.
- Shift-immediate case: I with opcode 0010011 and funct3 001 or 101 packs {funct7, [4:0], rs1, funct3, rd, opcode}. Legal iff [31:5]==0.
- S: {[11:5], rs2, rs1, funct3, [4:0], opcode}. Legal iff [31:11] are all equal.
- U: {[31:12], rd, opcode}. Legal iff [11:0]==0.
- J: {[20], [10:1], [11], [19:12], rd, opcode}. Legal iff [0]==0 and [31:20] are all equal.
- NULL_TYPE: {funct7, rs2, rs1, funct3, rd, opcode}. `imm` is ignored; always legal.
- Any other itype: illegal.

Error handling:
- An illegal bundle is still delivered, with `inst`=0 and `err`=1.
- Exactly one output word is produced per accepted input, in order.

Pipeline:
- Two registered stages.
- S1 captures the fields and computes legality.
- S2 holds the packed `inst` and `err`, which drive the outputs directly.

## Timing
Handshake:
- Transfer on input when `in_valid`&&`in_ready`; transfer on output when `out_valid`&&`out_ready`.
- s2_free = !s2_valid || `out_ready`.
- `in_ready` = !s1_valid || s2_free. It is combinational from `out_ready`, which is allowed.
- S1 advances to S2 when s1_valid && s2_free.

Latency and throughput:
- Bundle accepted at edge N → `out_valid` high after edge N+1.
- Throughput is one word per cycle while `out_ready`=1.

Output stability:
- While `out_valid`=1 and `out_ready`=0, `inst` and `err` hold stable.
- Upstream `in_valid` may drop without a transfer.
- Simultaneous input accept and output drain in the same cycle with both stages full: no bubble, no loss.

Counters:
- Update on the output-transfer edge only.
- `enc_count` wraps from all-ones to 0.
- `err_count` holds at all-ones.

Reset (`rst_n` low, asynchronous, any time):
- `out_valid`=0, `inst`=0, `err`=0, `enc_count`=0, `err_count`=0.
- Both stage valids are cleared; in-flight bundles are discarded.
- `in_ready`=1 while in reset and after release.

## Test plan
- I and shift encoding:
  - addi x1,x0,5 (I, opcode 0010011, funct3 0, rd 1, rs1 0, imm 5) → `inst`=0x00500093, `err`=0, valid two edges after accept.
  - srai x1,x1,3 (funct3 101, funct7 0100000, imm 3) → 0x4030D093.
- S/U/J encoding:
  - sw x2,8(x1) → 0x0020A423.
  - lui x5 with imm 0x12345000 → 0x123452B7.
  - jal x1 with imm 8 → 0x008000EF.
  - Each result round-trips through the decoder to the original imm.
- Illegal immediates:
  - I imm 0x00000800 → `inst`=0, `err`=1, `err_count`=1.
  - J imm 0x3 → `err`=1.
  - U imm 0x00000001 → `err`=1.
  - `enc_count` unchanged in all three cases.
- Backpressure: 4 back-to-back bundles with `out_ready`=0 for 5 cycles.
  - `in_ready` drops after 2 accepts.
  - Output holds the first word stable.
  - After release, 4 words arrive in order with no gaps.
  - `enc_count` ends at 4.
- Reset mid-flight: assert `rst_n` low asynchronously with both stages full.
  - `out_valid` falls immediately and counters are 0.
  - After release, a new bundle is encoded with normal 2-edge latency and no stale word appears.
- Counter limits: force CNT_W=4 and send 17 illegal plus 17 legal words.
  - `err_count`=15.
  - `enc_count`=1.
